// File: rtl/strace_buf_reader.sv
// Circular simple-trace buffer controller.
// Writes PCs on branch strobes and serves oldest-first reads to the host.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   trace_en             level, 0 blocks new writes (reads continue)
//   trace_clr            pulse, empties buffer and aborts any read
//   trace_wr_en/_data    branch strobe and hart PC from the write-enable gen
//   ram_wr_*             RAM write port (combinational from strobe/pointer)
//   ram_rd_en/_addr      RAM read port, data back one cycle later
//   ram_rd_data          RAM read data
//   rd_req               host request, sampled only in IDLE
//   rd_ready             host accepts response, sampled only in RESP
//   rd_valid/_data/_empty  registered response; empty carries data 0
//   fill_count           stored entries, 0..DEPTH
//   overflow             sticky, set when the oldest entry is dropped
module strace_buf_reader #(
    parameter int AW = 6,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          trace_en,
    input  logic          trace_clr,
    input  logic          trace_wr_en,
    input  logic [DW-1:0] trace_wr_data,
    output logic          ram_wr_en,
    output logic [AW-1:0] ram_wr_addr,
    output logic [DW-1:0] ram_wr_data,
    output logic          ram_rd_en,
    output logic [AW-1:0] ram_rd_addr,
    input  logic [DW-1:0] ram_rd_data,
    input  logic          rd_req,
    input  logic          rd_ready,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic          rd_empty,
    output logic [AW:0]   fill_count,
    output logic          overflow
);

    localparam logic [AW:0] FULL = {1'b1, {AW{1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        CAPT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t        state_q;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   fill_q, fill_d;
    logic          ovf_q, ovf_d;
    logic          rd_en_q;
    logic          valid_q;
    logic [DW-1:0] data_q;
    logic          empty_q;
    logic          pop;

    assign ram_wr_en   = trace_wr_en & trace_en & ~trace_clr;
    assign ram_wr_addr = wr_ptr_q;
    assign ram_wr_data = trace_wr_data;
    assign ram_rd_en   = rd_en_q;
    assign ram_rd_addr = rd_ptr_q;
    assign rd_valid    = valid_q;
    assign rd_data     = data_q;
    assign rd_empty    = empty_q;
    assign fill_count  = fill_q;
    assign overflow    = ovf_q;

    // The pop is committed in ISSUE, so the entry in flight is never
    // the one an overflow drops.
    assign pop = (state_q == ISSUE);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        ovf_d    = ovf_q;
        if (trace_clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            fill_d   = '0;
            ovf_d    = 1'b0;
        end else begin
            if (ram_wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)       rd_ptr_d = rd_ptr_q + 1'b1;
            if (ram_wr_en && !pop) begin
                if (fill_q == FULL) begin
                    // Full: drop the oldest entry to make room.
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    ovf_d    = 1'b1;
                end else begin
                    fill_d = fill_q + 1'b1;
                end
            end else if (!ram_wr_en && pop) begin
                fill_d = fill_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rd_en_q <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            empty_q <= 1'b0;
        end else if (trace_clr) begin
            state_q <= IDLE;
            rd_en_q <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            empty_q <= 1'b0;
        end else begin
            rd_en_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (rd_req) begin
                        if (fill_q != '0) begin
                            state_q <= ISSUE;
                            rd_en_q <= 1'b1;
                        end else begin
                            state_q <= RESP;
                            valid_q <= 1'b1;
                            data_q  <= '0;
                            empty_q <= 1'b1;
                        end
                    end
                end
                ISSUE: state_q <= CAPT;
                CAPT: begin
                    state_q <= RESP;
                    valid_q <= 1'b1;
                    data_q  <= ram_rd_data;
                    empty_q <= 1'b0;
                end
                RESP: begin
                    if (rd_ready) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_strace_buf_reader.sv
// Bench for strace_buf_reader: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_strace_buf_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        trace_en;
    logic        trace_clr;
    logic        trace_wr_en;
    logic [31:0] trace_wr_data;
    logic        ram_wr_en;
    logic [5:0]  ram_wr_addr;
    logic [31:0] ram_wr_data;
    logic        ram_rd_en;
    logic [5:0]  ram_rd_addr;
    logic [31:0] ram_rd_data;
    logic        rd_req;
    logic        rd_ready;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        rd_empty;
    logic [6:0]  fill_count;
    logic        overflow;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    strace_buf_reader #(.AW(6), .DW(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .trace_en(trace_en), .trace_clr(trace_clr),
        .trace_wr_en(trace_wr_en), .trace_wr_data(trace_wr_data),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr),
        .ram_wr_data(ram_wr_data),
        .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr),
        .ram_rd_data(ram_rd_data),
        .rd_req(rd_req), .rd_ready(rd_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_empty(rd_empty),
        .fill_count(fill_count), .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Synchronous RAM, read-before-write.
    logic [31:0] mem [64];
    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
        if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Reference model: the buffer is a queue of PCs; a read is a
    // transaction that takes the front at the ISSUE cycle and shows
    // it 3 cycles after the request (1 cycle for an empty response).
    logic [31:0] q[$];
    bit          m_ovf;
    int          m_wcnt, m_rcnt, m_wait;
    bit          m_valid, m_empty;
    logic [31:0] m_data, m_pend;

    task automatic m_clear();
        q.delete();
        m_ovf = 0; m_wcnt = 0; m_rcnt = 0; m_wait = 0;
        m_valid = 0; m_empty = 0; m_data = 0;
    endtask

    always @(posedge clk) begin
        int  sz0;
        bit  pop;
        if (!rst_n || trace_clr) begin
            m_clear();
        end else begin
            sz0 = q.size();
            pop = (m_wait == 2);
            if (pop) begin
                m_pend = q.pop_front();
                m_rcnt++;
            end
            if (trace_wr_en && trace_en) begin
                if (!pop && q.size() == 64) begin
                    void'(q.pop_front());
                    m_rcnt++;
                    m_ovf = 1;
                end
                q.push_back(trace_wr_data);
                m_wcnt++;
            end
            if (m_valid) begin
                if (rd_ready) m_valid = 0;
            end else if (m_wait == 2) begin
                m_wait = 1;
            end else if (m_wait == 1) begin
                m_wait = 0; m_valid = 1; m_data = m_pend; m_empty = 0;
            end else if (rd_req) begin
                if (sz0 != 0) m_wait = 2;
                else begin m_valid = 1; m_data = 0; m_empty = 1; end
            end
        end
    end

    always @(negedge clk) begin
        bit we;
        if (rst_n) begin
            we = trace_wr_en & trace_en & ~trace_clr;
            chk("m_fill", 32'(fill_count), 32'(q.size()));
            chk("m_ovf", 32'(overflow), 32'(m_ovf));
            chk("m_valid", 32'(rd_valid), 32'(m_valid));
            if (m_valid) begin
                chk("m_data", rd_data, m_data);
                chk("m_empty", 32'(rd_empty), 32'(m_empty));
            end
            chk("m_wr_en", 32'(ram_wr_en), 32'(we));
            if (we) begin
                chk("m_wr_addr", 32'(ram_wr_addr), 32'(m_wcnt % 64));
                chk("m_wr_data", ram_wr_data, trace_wr_data);
            end
            chk("m_rd_en", 32'(ram_rd_en), 32'(m_wait == 2));
            if (m_wait == 2)
                chk("m_rd_addr", 32'(ram_rd_addr), 32'(m_rcnt % 64));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] pc);
        trace_wr_en = 1'b1;
        trace_wr_data = pc;
        tick();
        trace_wr_en = 1'b0;
    endtask

    task automatic clr();
        trace_clr = 1'b1;
        tick();
        trace_clr = 1'b0;
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 20 && !rd_valid; i++) tick();
        chk("rd_timeout", 32'(rd_valid), 32'd1);
    endtask

    task automatic rd(output logic [31:0] d, output logic e,
                      output int lat);
        int t0;
        rd_req = 1'b1;
        t0 = cyc;
        tick();
        rd_req = 1'b0;
        wait_valid();
        lat = cyc - t0;
        d = rd_data;
        e = rd_empty;
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [31:0] d, d0;
        logic        e;
        int          lat;
        logic [31:0] exp_pc [3];

        rst_n = 1'b0;
        trace_en = 1'b1;
        trace_clr = 1'b0;
        trace_wr_en = 1'b0;
        trace_wr_data = '0;
        rd_req = 1'b0;
        rd_ready = 1'b0;
        m_clear();
        tick();
        tick();
        chk("rst_fill", 32'(fill_count), 0);
        chk("rst_valid", 32'(rd_valid), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_data", rd_data, 0);
        chk("rst_empty", 32'(rd_empty), 0);
        chk("rst_rden", 32'(ram_rd_en), 0);
        chk("rst_wraddr", 32'(ram_wr_addr), 0);
        rst_n = 1'b1;
        tick();

        // Basic in-order read
        exp_pc[0] = 32'h100; exp_pc[1] = 32'h200; exp_pc[2] = 32'h300;
        wr(32'h100); wr(32'h200); wr(32'h300);
        chk("basic_fill3", 32'(fill_count), 3);
        for (int i = 0; i < 3; i++) begin
            rd(d, e, lat);
            chk("basic_data", d, exp_pc[i]);
            chk("basic_lat", 32'(lat), 3);
            chk("basic_empty", 32'(e), 0);
        end
        chk("basic_fill0", 32'(fill_count), 0);
        chk("basic_ovf", 32'(overflow), 0);

        // Empty read
        rd(d, e, lat);
        chk("empty_lat", 32'(lat), 1);
        chk("empty_flag", 32'(e), 1);
        chk("empty_data", d, 0);
        chk("empty_drop", 32'(rd_valid), 0);

        // Overflow and wrap
        clr();
        for (int i = 0; i < 70; i++) begin
            trace_wr_en = 1'b1;
            trace_wr_data = 32'(i);
            #1;
            if (i == 63) chk("wrap_addr63", 32'(ram_wr_addr), 63);
            if (i == 64) chk("wrap_addr0", 32'(ram_wr_addr), 0);
            tick();
        end
        trace_wr_en = 1'b0;
        chk("ovf_fill", 32'(fill_count), 64);
        chk("ovf_flag", 32'(overflow), 1);
        for (int i = 0; i < 64; i++) begin
            rd(d, e, lat);
            if (i == 0)  chk("ovf_first", d, 6);
            if (i == 63) chk("ovf_last", d, 69);
        end
        chk("ovf_sticky", 32'(overflow), 1);

        // Clear mid-read with coincident write
        wr(32'hC1); wr(32'hC2); wr(32'hC3);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        tick();
        trace_clr = 1'b1;
        trace_wr_en = 1'b1;
        trace_wr_data = 32'hDEAD;
        #1;
        chk("clr_nowrite", 32'(ram_wr_en), 0);
        tick();
        trace_clr = 1'b0;
        trace_wr_en = 1'b0;
        chk("clr_fill", 32'(fill_count), 0);
        chk("clr_ovf", 32'(overflow), 0);
        chk("clr_valid", 32'(rd_valid), 0);
        chk("clr_data", rd_data, 0);
        tick(); tick();
        chk("clr_lost", 32'(rd_valid), 0);
        rd(d, e, lat);
        chk("clr_idle_lat", 32'(lat), 1);
        chk("clr_idle_empty", 32'(e), 1);

        // Full buffer with write coincident with ISSUE
        clr();
        for (int i = 0; i < 64; i++) wr(32'(1000 + i));
        chk("full_fill", 32'(fill_count), 64);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        trace_wr_en = 1'b1;
        trace_wr_data = 32'd5000;
        tick();
        trace_wr_en = 1'b0;
        chk("wp_fill", 32'(fill_count), 64);
        chk("wp_ovf", 32'(overflow), 0);
        wait_valid();
        chk("wp_data", rd_data, 1000);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        for (int i = 1; i < 65; i++) begin
            rd(d, e, lat);
            chk("wp_order", d, (i == 64) ? 32'd5000 : 32'(1000 + i));
        end
        chk("wp_fill0", 32'(fill_count), 0);

        // Backpressure
        clr();
        wr(32'hA1); wr(32'hA2);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        wait_valid();
        d0 = rd_data;
        chk("bp_first", d0, 32'hA1);
        chk("bp_fill1", 32'(fill_count), 1);
        for (int i = 0; i < 10; i++) begin
            trace_wr_en = (i < 5);
            trace_wr_data = 32'(32'hB0 + i);
            tick();
            chk("bp_stable", rd_data, 32'hA1);
            chk("bp_valid", 32'(rd_valid), 1);
        end
        trace_wr_en = 1'b0;
        chk("bp_fill6", 32'(fill_count), 6);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        rd(d, e, lat);
        chk("bp_next", d, 32'hA2);

        // trace_en low blocks writes
        trace_en = 1'b0;
        wr(32'h55);
        chk("en_block", 32'(fill_count), 5);
        trace_en = 1'b1;
        rd(d, e, lat);
        chk("en_read", d, 32'hB0);

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
